sr_latch_ctrl: RTL and testbench

Clocked command scheduler for a bank of N external SR latches shared by two requesters (A, B). Accepts set/reset commands over valid/ready, arbitrates round-robin, drives one-hot S or R pulses of fixed width, enforces a guard gap, then samples the latch Q output to confirm the write. Guarantees the forbidden S=R=1 condition never reaches any latch.

---
 rtl/sr_latch_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_sr_latch_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_ctrl.sv
// sr_latch_ctrl
// Command scheduler for a bank of N external SR latches shared by two
// requesters (A and B). Each accepted command drives a single S or R pulse
// of PULSE_W cycles, holds every drive low for GAP_W cycles, then samples
// the latch output in a CHECK cycle. The result is reported with a
// one-cycle done pulse on the following cycle.
//
// Ports
//   clk          rising-edge system clock
//   reset        synchronous, active-high reset
//   req_a_valid  requester A command valid
//   req_a_ready  requester A accept (handshake when valid & ready)
//   req_a_op     requester A operation, 1 = set, 0 = reset
//   req_a_idx    requester A target latch index
//   req_b_*      same as req_a_* for requester B
//   S, R         per-latch set / reset drives (registered, never both high)
//   Q            latch outputs fed back for the write check
//   busy         a command is in flight
//   done         one-cycle completion pulse
//   done_src     requester of the completed command (0 = A, 1 = B)
//   err          with done: Q mismatch or out-of-range index
module sr_latch_ctrl #(
  parameter int N       = 4,
  parameter int IDX_W   = 2,
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a_valid,
  output logic             req_a_ready,
  input  logic             req_a_op,
  input  logic [IDX_W-1:0] req_a_idx,
  input  logic             req_b_valid,
  output logic             req_b_ready,
  input  logic             req_b_op,
  input  logic [IDX_W-1:0] req_b_idx,
  output logic [N-1:0]     S,
  output logic [N-1:0]     R,
  input  logic [N-1:0]     Q,
  output logic             busy,
  output logic             done,
  output logic             done_src,
  output logic             err
);

  localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP,
    CHECK
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0] cnt, cnt_next;
  logic [N-1:0]     s_next, r_next;
  logic             done_next, err_next, src_next;

  // Captured command, valid from the first PULSE cycle through CHECK.
  logic             cmd_op;
  logic             cmd_src;
  logic [IDX_W-1:0] cmd_idx;

  // Round-robin pointer: set when B should win the next tie.
  logic prefer_b;

  logic             grant_a, grant_b, handshake;
  logic             sel_op, sel_src;
  logic [IDX_W-1:0] sel_idx;
  logic [N-1:0]     sel_onehot, cmd_onehot;
  logic             q_bit;

  // One-hot decode of a latch index. An index at or above N decodes to all
  // zeros, which is what suppresses S/R activity for a bad index.
  function automatic logic [N-1:0] decode(input logic [IDX_W-1:0] idx);
    logic [N-1:0] vec;
    vec = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == IDX_W'(i)) vec[i] = 1'b1;
    end
    return vec;
  endfunction

  // Arbitration and handshake. The grant is computed from valids only, so
  // the losing requester never sees ready even when the winner is accepted.
  always_comb begin
    grant_a     = req_a_valid && (!req_b_valid || !prefer_b);
    grant_b     = req_b_valid && !grant_a;
    req_a_ready = (state == IDLE) && !reset && grant_a;
    req_b_ready = (state == IDLE) && !reset && grant_b;
    handshake   = (req_a_valid && req_a_ready) || (req_b_valid && req_b_ready);
    sel_op      = grant_a ? req_a_op  : req_b_op;
    sel_idx     = grant_a ? req_a_idx : req_b_idx;
    sel_src     = !grant_a;
  end

  assign sel_onehot = decode(sel_idx);
  assign cmd_onehot = decode(cmd_idx);

  // A bad index masks Q entirely, so it compares as 0 and err is forced
  // separately below.
  assign q_bit = |(Q & cmd_onehot);

  assign busy = (state != IDLE);

  // Next-state logic. S/R for the first pulse cycle are loaded at the
  // handshake edge from the incoming command so the pulse starts one cycle
  // after acceptance; during PULSE they simply hold.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    s_next     = '0;
    r_next     = '0;
    done_next  = 1'b0;
    err_next   = err;
    src_next   = done_src;

    unique case (state)
      IDLE: begin
        if (handshake) begin
          state_next = PULSE;
          cnt_next   = '0;
          s_next     = sel_op  ? sel_onehot : '0;
          r_next     = !sel_op ? sel_onehot : '0;
        end
      end

      PULSE: begin
        if (cnt == CNT_W'(PULSE_W - 1)) begin
          state_next = GAP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
          s_next   = S;
          r_next   = R;
        end
      end

      GAP: begin
        if (cnt == CNT_W'(GAP_W - 1)) begin
          state_next = CHECK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      CHECK: begin
        state_next = IDLE;
        done_next  = 1'b1;
        err_next   = (cmd_onehot == '0) || (q_bit != cmd_op);
        src_next   = cmd_src;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers. Reset drops any in-flight command without
  // producing a done and returns the arbiter to favouring A.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      S        <= '0;
      R        <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      done_src <= 1'b0;
      prefer_b <= 1'b0;
      cmd_op   <= 1'b0;
      cmd_src  <= 1'b0;
      cmd_idx  <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      S        <= s_next;
      R        <= r_next;
      done     <= done_next;
      err      <= err_next;
      done_src <= src_next;
      if (handshake) begin
        cmd_op   <= sel_op;
        cmd_src  <= sel_src;
        cmd_idx  <= sel_idx;
        prefer_b <= !sel_src;
      end
    end
  end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// tb_sr_latch_ctrl
// Scoreboard bench for sr_latch_ctrl. A driver issues commands and, from a
// cycle-level model of the scheduler's rules (fixed latency, round-robin
// tie-break, pulse and busy windows), predicts readys, S/R drive, busy and
// the done report. Expected completions go into a queue that a separate
// monitor drains when done is due. A behavioural SR latch closes the loop
// on Q, with an optional stuck-at-0 mask to force write failures.
module tb_sr_latch_ctrl;

  localparam int N       = 4;
  localparam int IDX_W   = 3;
  localparam int PULSE_W = 2;
  localparam int GAP_W   = 1;
  localparam int LAT     = PULSE_W + GAP_W + 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_a_valid = 1'b0;
  logic             req_a_ready;
  logic             req_a_op = 1'b0;
  logic [IDX_W-1:0] req_a_idx = '0;
  logic             req_b_valid = 1'b0;
  logic             req_b_ready;
  logic             req_b_op = 1'b0;
  logic [IDX_W-1:0] req_b_idx = '0;
  logic [N-1:0]     S, R, Q;
  logic             busy, done, done_src, err;

  typedef struct {
    int src;
    int err;
    int due;
  } exp_t;

  exp_t sb_q[$];

  int cyc = 0;
  int free_cyc = 0;
  bit prefer_b = 1'b0;
  int plo = 1, phi = 0, blo = 1, bhi = 0;
  logic [N-1:0] spat = '0, rpat = '0;
  bit exp_ready_a = 1'b0, exp_ready_b = 1'b0;
  bit granted_a = 1'b0, granted_b = 1'b0;
  logic [N-1:0] latch_q = '0, stuck = '0, exp_latch = '0;
  int vectors = 0, miscompares = 0;
  int handshakes = 0, flushed = 0, dones_seen = 0;
  bit chk_en = 1'b0;

  sr_latch_ctrl #(
    .N(N),
    .IDX_W(IDX_W),
    .PULSE_W(PULSE_W),
    .GAP_W(GAP_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_a_valid(req_a_valid),
    .req_a_ready(req_a_ready),
    .req_a_op(req_a_op),
    .req_a_idx(req_a_idx),
    .req_b_valid(req_b_valid),
    .req_b_ready(req_b_ready),
    .req_b_op(req_b_op),
    .req_b_idx(req_b_idx),
    .S(S),
    .R(R),
    .Q(Q),
    .busy(busy),
    .done(done),
    .done_src(done_src),
    .err(err)
  );

  always #5 clk = ~clk;

  // Cycle counter: after the k-th rising edge the bench is in cycle k.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SR latch bank; a stuck bit forces that Q low.
  always @(posedge clk) latch_q <= (latch_q & ~R) | S;
  assign Q = latch_q & ~stuck;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Drives one cycle of inputs shortly after the rising edge and advances
  // the reference model for the edge that will end this cycle.
  task automatic applyStimulus(input bit rst, input bit av, input bit aop, input int aidx,
                               input bit bv, input bit bop, input int bidx);
    bit op;
    int idx;
    int e;
    @(posedge clk);
    #1;
    reset       = rst;
    req_a_valid = av;
    req_a_op    = aop;
    req_a_idx   = IDX_W'(aidx);
    req_b_valid = bv;
    req_b_op    = bop;
    req_b_idx   = IDX_W'(bidx);
    granted_a   = 1'b0;
    granted_b   = 1'b0;
    if (rst) begin
      if (phi > cyc) phi = cyc;
      if (bhi > cyc) bhi = cyc;
      while (sb_q.size() > 0 && sb_q[$].due > cyc) begin
        void'(sb_q.pop_back());
        flushed++;
      end
      free_cyc = cyc + 1;
      prefer_b = 1'b0;
    end else if (cyc >= free_cyc) begin
      granted_a = av && (!bv || !prefer_b);
      granted_b = bv && !granted_a;
      if (granted_a || granted_b) begin
        op   = granted_a ? aop : bop;
        idx  = granted_a ? aidx : bidx;
        spat = '0;
        rpat = '0;
        e    = 1;
        if (idx < N) begin
          if (op) spat[idx] = 1'b1;
          else    rpat[idx] = 1'b1;
          exp_latch[idx] = op;
          e = (op && stuck[idx]) ? 1 : 0;
        end
        plo      = cyc + 1;
        phi      = cyc + PULSE_W;
        blo      = cyc + 1;
        bhi      = cyc + PULSE_W + GAP_W + 1;
        free_cyc = cyc + LAT;
        sb_q.push_back('{src: int'(granted_b), err: e, due: cyc + LAT});
        prefer_b = granted_a;
        handshakes++;
      end
    end
    exp_ready_a = granted_a;
    exp_ready_b = granted_b;
  endtask

  // Keeps each requested side valid until the model grants it.
  task automatic issue(input bit wa, input bit aop, input int aidx,
                       input bit wb, input bit bop, input int bidx);
    int guard = 0;
    while ((wa || wb) && guard < 100) begin
      applyStimulus(1'b0, wa, aop, aidx, wb, bop, bidx);
      if (granted_a) wa = 1'b0;
      if (granted_b) wb = 1'b0;
      guard++;
    end
    checkOutput("grant_timeout", {31'd0, (wa || wb)}, 32'd0);
  endtask

  task automatic waitIdle();
    while (cyc <= free_cyc) applyStimulus(1'b0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: checks readys, drive windows and invariants every cycle, and
  // pops the scoreboard when a completion is due.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      checkOutput("ready_a", {31'd0, req_a_ready}, {31'd0, exp_ready_a});
      checkOutput("ready_b", {31'd0, req_b_ready}, {31'd0, exp_ready_b});
      checkOutput("S", 32'(S), (cyc >= plo && cyc <= phi) ? 32'(spat) : 32'd0);
      checkOutput("R", 32'(R), (cyc >= plo && cyc <= phi) ? 32'(rpat) : 32'd0);
      checkOutput("busy", {31'd0, busy}, (cyc >= blo && cyc <= bhi) ? 32'd1 : 32'd0);
      checkOutput("s_and_r", 32'(S & R), 32'd0);
      checkOutput("sr_onehot", ($countones(S | R) <= 1) ? 32'd1 : 32'd0, 32'd1);
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        e = sb_q.pop_front();
        checkOutput("done", {31'd0, done}, 32'd1);
        if (done) begin
          checkOutput("done_src", {31'd0, done_src}, 32'(e.src));
          checkOutput("err", {31'd0, err}, 32'(e.err));
        end
      end else begin
        checkOutput("done", {31'd0, done}, 32'd0);
      end
      if (done) dones_seen++;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rand_hs;
    int guard;
    bit av, bv;

    applyStimulus(1'b1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b1, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    @(negedge clk);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_done_src", {31'd0, done_src}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);

    // A sets latch 2.
    $display("[TB] scenario: single set from A");
    issue(1'b1, 1'b1, 2, 1'b0, 0, 0);
    waitIdle();
    checkOutput("t1_q2", {31'd0, Q[2]}, 32'd1);

    // Simultaneous requests after reset: A first, then B in A's done cycle.
    $display("[TB] scenario: simultaneous A/B after reset");
    applyStimulus(1'b1, 0, 0, 0, 0, 0, 0);
    issue(1'b1, 1'b1, 1, 1'b1, 1'b0, 1);
    waitIdle();
    checkOutput("t2_q1", {31'd0, Q[1]}, 32'd0);

    // Latch 3 stuck low: the write must be reported as failed.
    $display("[TB] scenario: stuck latch");
    stuck = 4'b1000;
    issue(1'b1, 1'b1, 3, 1'b0, 0, 0);
    waitIdle();
    stuck = '0;

    // Out-of-range index from B.
    $display("[TB] scenario: bad index");
    issue(1'b0, 0, 0, 1'b1, 1'b0, 5);
    waitIdle();

    // Reset during the second pulse cycle, then a tie must go to A.
    $display("[TB] scenario: reset mid-pulse");
    issue(1'b1, 1'b1, 0, 1'b0, 0, 0);
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b0, 1, 1, 1, 1, 1, 2);
    @(negedge clk);
    checkOutput("t5_ready_a", {31'd0, req_a_ready}, 32'd1);
    checkOutput("t5_busy", {31'd0, busy}, 32'd0);
    waitIdle();

    // Randomised traffic from both sides with occasional resets.
    $display("[TB] scenario: random traffic");
    rand_hs = 0;
    guard   = 0;
    while (rand_hs < 500 && guard < 20000) begin
      av = ($urandom_range(0, 2) != 0);
      bv = ($urandom_range(0, 2) != 0);
      applyStimulus(($urandom_range(0, 199) == 0), av, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 5)), bv, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 5)));
      if (granted_a || granted_b) rand_hs++;
      guard++;
    end
    checkOutput("random_progress", (rand_hs >= 500) ? 32'd1 : 32'd0, 32'd1);
    waitIdle();
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0);

    checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
    checkOutput("done_count", 32'(dones_seen), 32'(handshakes - flushed));
    checkOutput("latch_state", 32'(Q), 32'(exp_latch & ~stuck));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
